ff_add_255: RTL

FF_ADD_255 -- requirements
Module: ff_add_255

---
 rtl/ff_add_255.sv | 118 +++++++++++
 1 files changed

// File: rtl/ff_add_255.sv
// Modular adder over GF(2^255-19): limb-serial add, then a limb-serial
// conditional subtraction of P; result is canonical for canonical inputs.
module ff_add_255 #(
  parameter int unsigned LIMB_W = 51
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic         busy,
  output logic [254:0] result,
  output logic         valid
);

  localparam int unsigned NL = 255 / LIMB_W;
  localparam int unsigned CW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NL - 1);
  localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

  typedef enum logic [1:0] {IDLE, ADD, SUB, DONE} state_t;

  state_t         state_q, state_d;
  logic [254:0]   a_q, a_d, b_q, b_d;
  logic [255:0]   sum_q, sum_d;
  logic [254:0]   diff_q, diff_d;
  logic [254:0]   result_q, result_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;

  logic [8:0]        idx;
  logic [LIMB_W-1:0] a_l, b_l, s_l, p_l;
  logic [LIMB_W:0]   add_w, sub_w;

  assign idx   = 9'(cnt_q * LIMB_W);
  assign a_l   = a_q[idx +: LIMB_W];
  assign b_l   = b_q[idx +: LIMB_W];
  assign s_l   = sum_q[idx +: LIMB_W];
  assign p_l   = P[idx +: LIMB_W];
  // carry_q doubles as the borrow during SUB; it is cleared between phases
  assign add_w = {1'b0, a_l} + {1'b0, b_l} + {{LIMB_W{1'b0}}, carry_q};
  assign sub_w = {1'b0, s_l} - {1'b0, p_l} - {{LIMB_W{1'b0}}, carry_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    diff_d   = diff_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        sum_d[idx +: LIMB_W] = add_w[LIMB_W-1:0];
        carry_d              = add_w[LIMB_W];
        if (cnt_q == LAST) begin
          sum_d[255] = add_w[LIMB_W];
          carry_d    = 1'b0;
          cnt_d      = '0;
          state_d    = SUB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SUB: begin
        diff_d[idx +: LIMB_W] = sub_w[LIMB_W-1:0];
        carry_d               = sub_w[LIMB_W];
        if (cnt_q == LAST) begin
          // diff_d already holds the final limb, so the select sees the full value
          result_d = (sum_q[255] | ~sub_w[LIMB_W]) ? diff_d : sum_q[254:0];
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      diff_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
    end
  end

  assign busy   = (state_q == ADD) || (state_q == SUB);
  assign valid  = (state_q == DONE);
  assign result = result_q;

endmodule
